multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle sequencer for the RV64 core. It fetches each instruction over a req/ack instruction-memory port and latches the decoder's control outputs. It then steps the shared ALU, register file and data memory through EXEC, MEM and WB, gating every architectural write enable. It also resolves branch PC selection, traps on illegal opcodes and on memory timeouts, and keeps retired-instruction and cycle counters.

## Interface
Parameters:
- TIMEOUT, 255: maximum wait cycles for any memory ack before trapping (1..65535).
- CNT_W, 64: width of the instret and cycle counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- opcode  in  7  inst[6:0] from the instruction register.
- dec_werf, dec_mwr, dec_bsel  in  1 each  decoder outputs.
- dec_wdsel, dec_pcsel  in  2 each  decoder outputs.
- br_taken  in  1  ALU branch-compare result; valid in EXEC.
- imem_ack, dmem_ack  in  1 each  memory completion strobes.
- imem_req, dmem_req  out  1 each  memory request; held until ack.
- ir_we  out  1  instruction register load strobe.
- pc_we  out  1  PC update strobe.
- rf_we  out  1  register file write enable.
- dmem_we  out  1  data memory write qualifier.
- pc_sel  out  2  resolved PC source (00 +4, 01 branch, 10 jalr, 11 jal).
- wdsel_q  out  2  latched writeback select.
- bsel_q  out  1  latched ALU B-input select.
- trap  out  1  sticky halt flag.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- state  out  3  current FSM state, for debug.
- instret, cycles  out  CNT_W each  performance counters.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: imem_req=1.
  - On imem_ack: ir_we=1 in the same cycle, then go to DECODE.
- DECODE: opcode legal set is 0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 1101111.
  - Illegal opcode: go to TRAP with cause 01.
  - Legal opcode: register dec_werf, dec_mwr, dec_bsel, dec_wdsel and dec_pcsel into *_q registers, then go to EXEC.
- EXEC: one cycle.
  - If pcsel_q==01 and br_taken==0, overwrite pcsel_q with 00.
  - Next state is MEM for opcodes 0000011 and 0100011, else WB.
- MEM: dmem_req=1 and dmem_we=mwr_q.
  - On dmem_ack: go to WB.
- WB: rf_we=werf_q and pc_we=1 for exactly this one cycle; instret increments; then go to FETCH.
- pc_sel is driven from pcsel_q in every state; it is only consumed when pc_we=1.
- TRAP: all strobes and requests are 0; trap=1. TRAP exits only via reset.
- Timeout: a wait counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - Reaching TIMEOUT with no ack: go to TRAP with cause 10 (FETCH) or 11 (MEM).
  - An ack in the same cycle as the limit wins; no trap.
- cycles increments every cycle while not in TRAP.
- instret and cycles wrap modulo 2^CNT_W.
- Acks are ignored outside their own wait state (FETCH for imem_ack, MEM for dmem_ack).

## Timing
- Reset values: state=FETCH, imem_req=1 combinationally after reset release, all other strobes 0, *_q=0, trap=0, trap_cause=00, counters=0.
- Asserting rst_n low mid-operation returns to FETCH immediately; a pending memory request drops in that cycle.
- Minimum latency with zero-wait acks (ack in the first req cycle):
  - ALU/branch/jump instructions: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Loads and stores: 5 cycles.
- Each wait cycle of a memory adds one cycle.
- Requests are level signals: asserted from state entry until the ack cycle, never withdrawn early except by trap or reset.
- Outputs are Moore-style from state and *_q, except ir_we, which is imem_req & imem_ack.

## Structure
- Shared package rv_ctrl_pkg holds:
  - the state enum;
  - opcode constants (OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR, OP_JAL);
  - trap cause constants;
  - pcsel encodings.
- The decoder will import the same opcode constants.
- One sub-module, ctrl_wait_timer: a wait counter with clear and enable inputs and a timeout output, instantiated once and shared by FETCH and MEM.

## Test plan
- R-type add (opcode 0110011, werf=1), acks in the first cycle: states 0,1,2,4,0; rf_we=1 and pc_we=1 only in WB; pc_sel=00; instret=1 and cycles=4.
- Store (0100011, mwr=1), dmem_ack after 3 wait cycles: MEM lasts 4 cycles with dmem_we=1 throughout; rf_we=0; instret=1 after 8 cycles total.
- BEQ (pcsel=01): with br_taken=0, pc_sel=00 at WB; with br_taken=1, pc_sel=01. JAL gives pc_sel=11 and rf_we=1.
- Opcode 0000000: TRAP entered the cycle after DECODE with trap_cause=01; no further imem_req; cycles frozen; rst_n low then high restarts in FETCH with all outputs at reset values.
- TIMEOUT=4, imem_ack never asserted: TRAP after 4 FETCH cycles with cause 10. Repeat with the ack arriving on the 4th cycle: no trap.
- rst_n pulsed low during MEM with dmem_req=1: dmem_req=0 in the same cycle, state=FETCH, instret unchanged at its reset value 0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the RV64 multi-cycle control path: FSM states, opcodes,
// trap causes and PC-select encodings. The instruction decoder imports the same opcodes.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

    localparam logic [1:0] PCSEL_PLUS4 = 2'b00;
    localparam logic [1:0] PCSEL_BR    = 2'b01;
    localparam logic [1:0] PCSEL_JALR  = 2'b10;
    localparam logic [1:0] PCSEL_JAL   = 2'b11;

    function automatic logic op_is_legal(input logic [6:0] op);
        return (op == OP_R)  || (op == OP_I)  || (op == OP_LD) || (op == OP_ST) ||
               (op == OP_BR) || (op == OP_JALR) || (op == OP_JAL);
    endfunction

    function automatic logic op_is_mem(input logic [6:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the sequencer and the datapath / memories / decoder.
// slave = sequencer side, master = environment (datapath, memories, decoder).
interface multicycle_ctrl_if #(
    parameter int CNT_W = 64
);
    logic [6:0]       opcode;
    logic             dec_werf;
    logic             dec_mwr;
    logic             dec_bsel;
    logic [1:0]       dec_wdsel;
    logic [1:0]       dec_pcsel;
    logic             br_taken;
    logic             imem_ack;
    logic             dmem_ack;

    logic             imem_req;
    logic             dmem_req;
    logic             ir_we;
    logic             pc_we;
    logic             rf_we;
    logic             dmem_we;
    logic [1:0]       pc_sel;
    logic [1:0]       wdsel_q;
    logic             bsel_q;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;
    logic [CNT_W-1:0] cycles;

    modport slave (
        input  opcode, dec_werf, dec_mwr, dec_bsel, dec_wdsel, dec_pcsel,
               br_taken, imem_ack, dmem_ack,
        output imem_req, dmem_req, ir_we, pc_we, rf_we, dmem_we, pc_sel,
               wdsel_q, bsel_q, trap, trap_cause, state, instret, cycles
    );

    modport master (
        output opcode, dec_werf, dec_mwr, dec_bsel, dec_wdsel, dec_pcsel,
               br_taken, imem_ack, dmem_ack,
        input  imem_req, dmem_req, ir_we, pc_we, rf_we, dmem_we, pc_sel,
               wdsel_q, bsel_q, trap, trap_cause, state, instret, cycles
    );

endinterface

// File: rtl/ctrl_wait_timer.sv
// Memory-ack wait counter shared by FETCH and MEM; timeout_o is combinational from the count.
// timeout_o rises in the TIMEOUT-th consecutive enabled cycle; clr_i dominates en_i.
module ctrl_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count holds the number of already-elapsed wait cycles, so the limit
    // is seen one below TIMEOUT; an ack in that cycle is resolved by the caller.
    assign timeout_o = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// RV64 multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with traps and perf counters.
// Latency 4 cycles (5 for loads/stores) plus one per memory wait cycle; requests held until ack.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic             werf_q, mwr_q, bsel_q;
    logic [1:0]       wdsel_q, pcsel_q;
    logic [CNT_W-1:0] instret_q, cycles_q;

    logic waiting;
    logic wait_ack;
    logic tmo;

    assign waiting  = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign wait_ack = (state_q == ST_FETCH) ? bus.imem_ack : bus.dmem_ack;

    ctrl_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!waiting),
        .en_i      (waiting && !wait_ack),
        .timeout_o (tmo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    state_d = ST_DECODE;
                end else if (tmo) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IMEM_TO;
                end
            end
            ST_DECODE: begin
                if (op_is_legal(bus.opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: state_d = op_is_mem(bus.opcode) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (bus.dmem_ack) begin
                    state_d = ST_WB;
                end else if (tmo) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
    end

    always_comb begin
        bus.imem_req   = (state_q == ST_FETCH);
        bus.dmem_req   = (state_q == ST_MEM);
        bus.ir_we      = bus.imem_req && bus.imem_ack;
        bus.dmem_we    = (state_q == ST_MEM) && mwr_q;
        bus.rf_we      = (state_q == ST_WB) && werf_q;
        bus.pc_we      = (state_q == ST_WB);
        bus.pc_sel     = pcsel_q;
        bus.wdsel_q    = wdsel_q;
        bus.bsel_q     = bsel_q;
        bus.trap       = (state_q == ST_TRAP);
        bus.trap_cause = cause_q;
        bus.state      = state_q;
        bus.instret    = instret_q;
        bus.cycles     = cycles_q;
    end

    // Decoder outputs are captured once in DECODE; EXEC only demotes an
    // untaken branch so pc_sel is final by the time WB strobes pc_we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            werf_q  <= 1'b0;
            mwr_q   <= 1'b0;
            bsel_q  <= 1'b0;
            wdsel_q <= 2'b00;
            pcsel_q <= PCSEL_PLUS4;
        end else if (state_q == ST_DECODE && op_is_legal(bus.opcode)) begin
            werf_q  <= bus.dec_werf;
            mwr_q   <= bus.dec_mwr;
            bsel_q  <= bus.dec_bsel;
            wdsel_q <= bus.dec_wdsel;
            pcsel_q <= bus.dec_pcsel;
        end else if (state_q == ST_EXEC && pcsel_q == PCSEL_BR && !bus.br_taken) begin
            pcsel_q <= PCSEL_PLUS4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
            cycles_q  <= '0;
        end else begin
            if (state_q == ST_WB) begin
                instret_q <= instret_q + 1'b1;
            end
            if (state_q != ST_TRAP) begin
                cycles_q <= cycles_q + 1'b1;
            end
        end
    end

endmodule
